// File: rtl/clocked_sense_amp.sv
// clocked_sense_amp
//
// Clocked read front-end for the mixed-signal SRAM macro. A read request is
// accepted in IDLE. The block then runs PRECHARGE for 1 cycle and DEVELOP
// for SETTLE_CYC cycles, with the wordline high. In SENSE the real-valued
// differential bitline pair of every column is resolved into a latched
// rail-to-rail output.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   rd_req     read request, honoured only while rd_rdy is high
//   rd_addr    row address, captured on acceptance
//   rd_rdy     high only in IDLE
//   wl_rd      per-row wordline drive (VDD on the selected row, else VSS)
//   pre        bitline precharge drive (VDD in PRECHARGE, else VSS)
//   bl, blb    per-column true / complementary bitline voltages
//   dout       sensed data as rail voltages, held between reads
//   dout_bits  logic copy of dout
//   dout_vld   one-cycle pulse when dout / err are updated
//   err        per-column insufficient-margin flags for the last read
module clocked_sense_amp #(
  parameter int  ROWS       = 16,
  parameter int  COLS       = 8,
  parameter int  SETTLE_CYC = 2,
  parameter real VDD        = 1.5,
  parameter real VSS        = 0.0,
  parameter real VMARGIN    = 0.2,
  localparam int AW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_rdy,
  output real             wl_rd [0:ROWS-1],
  output real             pre,
  input  real             bl    [0:COLS-1],
  input  real             blb   [0:COLS-1],
  output real             dout  [0:COLS-1],
  output logic [COLS-1:0] dout_bits,
  output logic            dout_vld,
  output logic [COLS-1:0] err
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    DEVELOP   = 2'd2,
    SENSE     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     addr_p0;
  logic              addr_ok_p0;
  logic [COLS-1:0]   sense_bits;
  logic [COLS-1:0]   sense_err;

  // Decision for one column. The result is {err, bit}. Inside the margin
  // window the previous bit is kept, so a weak column cannot flip stored data.
  function automatic logic [1:0] resolve(input real d, input logic prev);
    if (d >= VMARGIN)
      return 2'b01;
    else if (d <= -VMARGIN)
      return 2'b00;
    else
      return {1'b1, prev};
  endfunction

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---- FSM next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (rd_req) state_nxt = PRECHARGE;
      PRECHARGE: state_nxt = DEVELOP;
      DEVELOP:   if (cnt == '0) state_nxt = SENSE;
      SENSE:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // ---- request capture and develop counter ----
  // The counter is loaded during PRECHARGE, so DEVELOP starts with
  // SETTLE_CYC-1 and leaves when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == PRECHARGE) begin
      cnt <= CNT_W'(SETTLE_CYC - 1);
    end else if (state == DEVELOP && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && rd_req)
      addr_p0 <= rd_addr;
  end

  // When ROWS is not a power of two, the address bus can carry rows that do not exist.
  assign addr_ok_p0 = ({1'b0, addr_p0} < (AW+1)'(ROWS));

  // ---- column decision (evaluated at the SENSE exit edge) ----
  always_comb begin
    sense_bits = '0;
    sense_err  = '0;
    for (int c = 0; c < COLS; c++) begin
      logic [1:0] r;
      r             = resolve(bl[c] - blb[c], dout_bits[c]);
      sense_bits[c] = r[0];
      sense_err[c]  = r[1];
    end
  end

  // ---- sensed output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_bits <= '0;
      err       <= '0;
      dout_vld  <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      if (state == SENSE) begin
        dout_vld <= 1'b1;
        if (addr_ok_p0) begin
          dout_bits <= sense_bits;
          err       <= sense_err;
        end else begin
          err       <= '1;
        end
      end
    end
  end

  // ---- FSM output decode ----
  // The drives are decoded only from registered state. Because of this,
  // pre and the wordline can never be high in the same cycle.
  always_comb begin
    rd_rdy = (state == IDLE);
    pre    = (state == PRECHARGE) ? VDD : VSS;
    for (int r = 0; r < ROWS; r++) begin
      wl_rd[r] = VSS;
      if ((state == DEVELOP || state == SENSE) && addr_ok_p0 && addr_p0 == AW'(r))
        wl_rd[r] = VDD;
    end
    for (int c = 0; c < COLS; c++)
      dout[c] = dout_bits[c] ? VDD : VSS;
  end

endmodule

// File: tb/tb_clocked_sense_amp.sv
module tb_clocked_sense_amp;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_req = 1'b0, rd_req2 = 1'b0;
  logic [3:0] rd_addr = '0, rd_addr2 = '0;
  real        bl  [0:7];
  real        blb [0:7];

  logic       rd_rdy, dout_vld, rd_rdy2, dout_vld2;
  real        wl_rd  [0:15];
  real        wl_rd2 [0:11];
  real        pre, pre2;
  real        dout [0:7];
  real        dout2 [0:7];
  logic [7:0] dout_bits, err, dout_bits2, err2;

  int checks   = 0;
  int failures = 0;

  clocked_sense_amp #(.ROWS(16), .COLS(8), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .wl_rd(wl_rd), .pre(pre), .bl(bl), .blb(blb), .dout(dout),
    .dout_bits(dout_bits), .dout_vld(dout_vld), .err(err)
  );

  clocked_sense_amp #(.ROWS(12), .COLS(8), .SETTLE_CYC(2)) dut12 (
    .clk(clk), .rst(rst), .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_rdy(rd_rdy2),
    .wl_rd(wl_rd2), .pre(pre2), .bl(bl), .blb(blb), .dout(dout2),
    .dout_bits(dout_bits2), .dout_vld(dout_vld2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] wl_mask();
    logic [15:0] m = '0;
    for (int r = 0; r < 16; r++) m[r] = (wl_rd[r] != 0.0);
    return m;
  endfunction

  function automatic logic [15:0] wl2_mask();
    logic [15:0] m = '0;
    for (int r = 0; r < 12; r++) m[r] = (wl_rd2[r] != 0.0);
    return m;
  endfunction

  function automatic bit dout_is(input logic [7:0] exp);
    bit ok = 1'b1;
    for (int c = 0; c < 8; c++) if (dout[c] != (exp[c] ? 1.5 : 0.0)) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit dout2_is(input logic [7:0] exp);
    bit ok = 1'b1;
    for (int c = 0; c < 8; c++) if (dout2[c] != (exp[c] ? 1.5 : 0.0)) ok = 1'b0;
    return ok;
  endfunction

  task automatic set_cols(input logic [7:0] pat);
    for (int c = 0; c < 8; c++) begin
      bl[c]  = pat[c] ? 1.5 : 0.0;
      blb[c] = pat[c] ? 0.0 : 1.5;
    end
  endtask

  // Issues one read on the main DUT and returns in the dout_vld cycle.
  task automatic do_read(input logic [3:0] a, output bit timed_out);
    rd_req = 1'b1; rd_addr = a;
    tick;
    rd_req = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (dout_vld === 1'b1) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; set_cols(8'h00);
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (rd_rdy !== 1'b1 || dout_vld !== 1'b0 || pre != 0.0 || wl_mask() !== 16'h0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: rdy=%b vld=%b pre=%f wl=%h, want 1 0 0.0 0000",
                 i, rd_rdy, dout_vld, pre, wl_mask());
      end
      checks++;
      if (dout_bits !== 8'h00 || err !== 8'h00 || !dout_is(8'h00)) begin
        failures++;
        $display("FAIL reset_data cyc%0d: dout_bits=%h err=%h, want 00 00", i, dout_bits, err);
      end
    end
  endtask

  task automatic test_read_timing;
    logic [15:0] exp_wl;
    set_cols(8'h55);
    rd_req = 1'b1; rd_addr = 4'd5;
    tick;
    rd_req = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      exp_wl = (k >= 1 && k <= 3) ? 16'h0020 : 16'h0000;
      checks++;
      if (pre != ((k == 0) ? 1.5 : 0.0) || wl_mask() !== exp_wl) begin
        failures++;
        $display("FAIL read5_drive k=%0d: pre=%f wl=%h, want pre=%f wl=%h",
                 k, pre, wl_mask(), (k == 0) ? 1.5 : 0.0, exp_wl);
      end
      checks++;
      if (dout_vld !== (k == 4) || rd_rdy !== (k >= 4)) begin
        failures++;
        $display("FAIL read5_hs k=%0d: vld=%b rdy=%b, want %b %b", k, dout_vld, rd_rdy, k == 4, k >= 4);
      end
      if (k == 4) begin
        checks++;
        if (dout_bits !== 8'h55 || err !== 8'h00 || !dout_is(8'h55)) begin
          failures++;
          $display("FAIL read5_data: dout_bits=%h err=%h, want 55 00", dout_bits, err);
        end
      end
      if (k < 5) tick;
    end
  endtask

  task automatic test_weak_margin;
    bit to;
    set_cols(8'h55); bl[3] = 0.80; blb[3] = 0.75;
    do_read(4'd2, to);
    checks++;
    if (to || dout_bits !== 8'h55 || err !== 8'h08) begin
      failures++;
      $display("FAIL weak_prev0: to=%b dout_bits=%h err=%h, want 0 55 08", to, dout_bits, err);
    end
    set_cols(8'hFF);
    do_read(4'd9, to);
    checks++;
    if (to || dout_bits !== 8'hFF || err !== 8'h00 || !dout_is(8'hFF)) begin
      failures++;
      $display("FAIL strong_ff: to=%b dout_bits=%h err=%h, want 0 ff 00", to, dout_bits, err);
    end
    set_cols(8'h00); bl[3] = 0.80; blb[3] = 0.75;
    do_read(4'd9, to);
    checks++;
    if (to || dout_bits !== 8'h08 || err !== 8'h08) begin
      failures++;
      $display("FAIL weak_prev1: to=%b dout_bits=%h err=%h, want 0 08 08", to, dout_bits, err);
    end
  endtask

  task automatic test_margin_boundary;
    bit to;
    set_cols(8'hFF);
    do_read(4'd1, to);
    set_cols(8'hF0);
    bl[0] = 0.2;  blb[0] = 0.0;   // exactly +margin -> 1
    bl[1] = 0.0;  blb[1] = 0.2;   // exactly -margin -> 0
    bl[2] = 0.75; blb[2] = 0.65;  // inside window -> keep 1
    bl[3] = 0.6;  blb[3] = 0.7;   // inside window -> keep 1
    bl[4] = 0.19; blb[4] = 0.0;   // just under margin -> keep 1
    do_read(4'd14, to);
    checks++;
    if (to || dout_bits !== 8'hFD || err !== 8'h1C) begin
      failures++;
      $display("FAIL margin_edge: to=%b dout_bits=%h err=%h, want 0 fd 1c", to, dout_bits, err);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_wl;
    int          active;
    set_cols(8'hA5);
    rd_req = 1'b1; rd_addr = 4'd0;
    tick;
    rd_addr = 4'd15;
    for (int k = 0; k <= 10; k++) begin
      exp_wl = (k >= 1 && k <= 3) ? 16'h0001 : (k >= 6 && k <= 8) ? 16'h8000 : 16'h0000;
      active = $countones(wl_mask()) + ((pre != 0.0) ? 1 : 0);
      checks++;
      if (wl_mask() !== exp_wl || pre != ((k == 0 || k == 5) ? 1.5 : 0.0) || active > 1) begin
        failures++;
        $display("FAIL b2b_drive k=%0d: wl=%h pre=%f active=%0d, want wl=%h", k, wl_mask(), pre, active, exp_wl);
      end
      checks++;
      if (dout_vld !== (k == 4 || k == 9)) begin
        failures++;
        $display("FAIL b2b_vld k=%0d: vld=%b want %b", k, dout_vld, (k == 4 || k == 9));
      end
      if (k == 9) begin
        checks++;
        if (dout_bits !== 8'hA5 || err !== 8'h00) begin
          failures++;
          $display("FAIL b2b_data: dout_bits=%h err=%h, want a5 00", dout_bits, err);
        end
      end
      if (k == 5) rd_req = 1'b0;
      if (k < 10) tick;
    end
  endtask

  task automatic test_reset_abort;
    set_cols(8'h0F);
    rd_req = 1'b1; rd_addr = 4'd7;
    tick;
    rd_req = 1'b0;
    tick;
    checks++;
    if (wl_mask() !== 16'h0080) begin
      failures++;
      $display("FAIL abort_develop: wl=%h want 0080", wl_mask());
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (wl_mask() !== 16'h0 || pre != 0.0 || rd_rdy !== 1'b1 || dout_vld !== 1'b0) begin
      failures++;
      $display("FAIL abort_ctrl: wl=%h pre=%f rdy=%b vld=%b, want 0000 0.0 1 0", wl_mask(), pre, rd_rdy, dout_vld);
    end
    checks++;
    if (dout_bits !== 8'h00 || err !== 8'h00 || !dout_is(8'h00)) begin
      failures++;
      $display("FAIL abort_data: dout_bits=%h err=%h, want 00 00", dout_bits, err);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++;
      if (dout_vld !== 1'b0 || wl_mask() !== 16'h0) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d: vld=%b wl=%h, want 0 0000", i, dout_vld, wl_mask());
      end
    end
  endtask

  task automatic test_reset_vs_req;
    rst = 1'b1; rd_req = 1'b1; rd_addr = 4'd3;
    tick;
    rst = 1'b0; rd_req = 1'b0;
    checks++;
    if (rd_rdy !== 1'b1 || pre != 0.0) begin
      failures++;
      $display("FAIL rst_wins0: rdy=%b pre=%f, want 1 0.0", rd_rdy, pre);
    end
    tick;
    checks++;
    if (rd_rdy !== 1'b1 || pre != 0.0 || wl_mask() !== 16'h0) begin
      failures++;
      $display("FAIL rst_wins1: rdy=%b pre=%f wl=%h, want 1 0.0 0000", rd_rdy, pre, wl_mask());
    end
  endtask

  task automatic test_out_of_range;
    bit to;
    set_cols(8'h3C);
    rd_req2 = 1'b1; rd_addr2 = 4'd3;
    tick;
    rd_req2 = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (dout_vld2 === 1'b1) begin to = 1'b0; break; end
    end
    checks++;
    if (to || dout_bits2 !== 8'h3C || err2 !== 8'h00) begin
      failures++;
      $display("FAIL oor_pre_read: to=%b dout_bits=%h err=%h, want 0 3c 00", to, dout_bits2, err2);
    end
    set_cols(8'hC3);
    rd_req2 = 1'b1; rd_addr2 = 4'd13;
    tick;
    rd_req2 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      checks++;
      if (wl2_mask() !== 16'h0 || pre2 != ((k == 0) ? 1.5 : 0.0) || dout_vld2 !== (k == 4)) begin
        failures++;
        $display("FAIL oor_seq k=%0d: wl=%h pre=%f vld=%b, want 0000 %f %b",
                 k, wl2_mask(), pre2, dout_vld2, (k == 0) ? 1.5 : 0.0, k == 4);
      end
      if (k == 4) begin
        checks++;
        if (dout_bits2 !== 8'h3C || err2 !== 8'hFF || !dout2_is(8'h3C)) begin
          failures++;
          $display("FAIL oor_data: dout_bits=%h err=%h, want 3c ff", dout_bits2, err2);
        end
      end
      if (k < 4) tick;
    end
    tick;
  endtask

  initial begin
    set_cols(8'h00);
    test_reset;
    test_read_timing;
    test_weak_margin;
    test_margin_boundary;
    test_back_to_back;
    test_reset_abort;
    test_reset_vs_req;
    test_out_of_range;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
